// File: rtl/game_pkg.sv
// Shared definitions for the pig playfield game controller: states, playfield
// geometry, timing constants and the box-overlap helper.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLAY      = 3'd1,
    PLACE     = 3'd2,
    PLACE_VEG = 3'd3,
    OVER      = 3'd4
  } state_t;

  localparam logic [10:0] MIN_X      = 11'd8;
  localparam logic [10:0] MAX_X      = 11'd632;
  localparam logic [10:0] MIN_Y      = 11'd8;
  localparam logic [10:0] MAX_Y      = 11'd472;
  localparam logic [10:0] SNACK_SIZE = 11'd16;
  localparam logic [10:0] VEG_SIZE   = 11'd16;
  localparam logic [10:0] PARK_XY    = 11'd2000;
  localparam int          TICK_DIV   = 25;
  localparam logic [7:0]  ROUND_SECS = 8'd30;
  localparam logic [7:0]  MAX_SCORE  = 8'd99;
  localparam int          MAX_TRIES  = 16;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;

  // Corners are 12-bit two's complement; x1/y1 are exclusive edges.
  typedef struct packed {
    logic [11:0] x0;
    logic [11:0] y0;
    logic [11:0] x1;
    logic [11:0] y1;
  } box_t;

  function automatic logic overlaps(input box_t b, input logic signed [11:0] x,
                                    input logic signed [11:0] y,
                                    input logic signed [11:0] sz);
    return !(((x + sz) <= $signed(b.x0)) || (x >= $signed(b.x1)) ||
             ((y + sz) <= $signed(b.y0)) || (y >= $signed(b.y1)));
  endfunction

endpackage

// File: rtl/item_placer.sv
// Picks a legal, non-overlapping top-left corner for a square item using a
// free-running LFSR, with a bounded number of tries and a fixed fallback.
module item_placer
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [10:0] size,
  input  box_t        avoid1,
  input  logic        avoid2_en,
  input  box_t        avoid2,
  output logic        done,
  output logic [10:0] x,
  output logic [10:0] y
);

  // Handshake: go is held high while a placement is wanted; done is high for
  // exactly one cycle with x/y valid in that same cycle. A go still high after
  // done starts a fresh placement with a cleared try count.
  logic [15:0]       lfsr_q, lfsr_d;
  logic [4:0]        tries_q, tries_d;
  logic [10:0]       cx, cy;
  logic signed [11:0] cx_s, cy_s, sz_s, fbx_s, fby_s;
  logic              in_bounds, clear_cand, clear_fb1;

  always_comb begin
    lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    cx         = MIN_X + {1'b0, lfsr_q[9:0]};
    cy         = MIN_Y + {2'b00, lfsr_q[15:7]};
    cx_s       = $signed({1'b0, cx});
    cy_s       = $signed({1'b0, cy});
    sz_s       = $signed({1'b0, size});
    fbx_s      = $signed({1'b0, MIN_X});
    fby_s      = $signed({1'b0, MIN_Y});
    in_bounds  = (({1'b0, cx} + {1'b0, size}) <= {1'b0, MAX_X}) &&
                 (({1'b0, cy} + {1'b0, size}) <= {1'b0, MAX_Y});
    clear_cand = !overlaps(avoid1, cx_s, cy_s, sz_s) &&
                 !(avoid2_en && overlaps(avoid2, cx_s, cy_s, sz_s));
    clear_fb1  = !overlaps(avoid1, fbx_s, fby_s, sz_s) &&
                 !(avoid2_en && overlaps(avoid2, fbx_s, fby_s, sz_s));
    done       = 1'b0;
    x          = cx;
    y          = cy;
    tries_d    = '0;
    if (go) begin
      // Once every try is spent the fallback is taken without a fresh candidate.
      if (tries_q == 5'(MAX_TRIES)) begin
        done = 1'b1;
        x    = clear_fb1 ? MIN_X : (MAX_X - size);
        y    = clear_fb1 ? MIN_Y : (MAX_Y - size);
      end else if (in_bounds && clear_cand) begin
        done = 1'b1;
      end else begin
        tries_d = tries_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q  <= LFSR_SEED;
      tries_q <= '0;
    end else begin
      lfsr_q  <= lfsr_d;
      tries_q <= tries_d;
    end
  end

endmodule

// File: rtl/round_sequencer.sv
// Game-level controller: idle/play/placement/game-over sequencing, round
// countdown timer, and snack/vegetable placement around the pig.
module round_sequencer
  import game_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               new_round,
  input  logic               vegetable_consumed,
  input  logic [7:0]         score,
  input  logic signed [10:0] posX,
  input  logic signed [10:0] posY,
  input  logic signed [10:0] posX_end,
  input  logic signed [10:0] posY_end,
  output logic               game_state,
  output logic               game_over,
  output logic               win,
  output logic               is_fifth_round,
  output logic [10:0]        snackX,
  output logic [10:0]        snackY,
  output logic [10:0]        vegetableX,
  output logic [10:0]        vegetableY,
  output logic [7:0]         round_num,
  output logic [7:0]         time_left,
  output state_t             dbg_state
);

  state_t      state_q, state_d;
  logic        start_q, new_round_q, veg_cons_q;
  logic        win_q, win_d, fifth_q, fifth_d;
  logic [10:0] snack_x_q, snack_x_d, snack_y_q, snack_y_d;
  logic [10:0] veg_x_q, veg_x_d, veg_y_q, veg_y_d;
  logic [7:0]  round_q, round_d, time_q, time_d;
  logic [4:0]  tick_q, tick_d;
  logic        start_rise, nr_rise, veg_rise;
  logic        pl_go, pl_avoid2_en, pl_done;
  logic [10:0] pl_size, pl_x, pl_y;
  box_t        pig_box, snack_box;

  assign start_rise = start & ~start_q;
  assign nr_rise    = new_round & ~new_round_q;
  assign veg_rise   = vegetable_consumed & ~veg_cons_q;

  assign pig_box   = '{x0: {posX[10], posX}, y0: {posY[10], posY},
                       x1: {posX_end[10], posX_end}, y1: {posY_end[10], posY_end}};
  assign snack_box = '{x0: {1'b0, snack_x_q}, y0: {1'b0, snack_y_q},
                       x1: {1'b0, snack_x_q + SNACK_SIZE}, y1: {1'b0, snack_y_q + SNACK_SIZE}};

  item_placer u_placer (
    .clk      (clk),
    .rst      (rst),
    .go       (pl_go),
    .size     (pl_size),
    .avoid1   (pig_box),
    .avoid2_en(pl_avoid2_en),
    .avoid2   (snack_box),
    .done     (pl_done),
    .x        (pl_x),
    .y        (pl_y)
  );

  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    fifth_d      = fifth_q;
    snack_x_d    = snack_x_q;
    snack_y_d    = snack_y_q;
    veg_x_d      = veg_x_q;
    veg_y_d      = veg_y_q;
    round_d      = round_q;
    time_d       = time_q;
    tick_d       = tick_q;
    pl_go        = 1'b0;
    pl_size      = SNACK_SIZE;
    pl_avoid2_en = 1'b0;
    case (state_q)
      IDLE: if (start_rise) state_d = PLAY;
      PLAY: begin
        if (score >= MAX_SCORE) begin
          win_d   = 1'b1;
          state_d = OVER;
        end else begin
          if (veg_rise) begin
            veg_x_d = PARK_XY;
            veg_y_d = PARK_XY;
          end
          // A snack eaten on the last tick still counts: new_round beats expiry.
          if (nr_rise) begin
            round_d = (round_q == 8'hFF) ? round_q : round_q + 8'd1;
            time_d  = ROUND_SECS;
            tick_d  = '0;
            state_d = PLACE;
          end else if (tick_q == 5'(TICK_DIV - 1)) begin
            tick_d = '0;
            if (time_q == 8'd1) begin
              time_d  = 8'd0;
              state_d = OVER;
            end else begin
              time_d = time_q - 8'd1;
            end
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
      PLACE: begin
        pl_go = 1'b1;
        if (pl_done) begin
          snack_x_d = pl_x;
          snack_y_d = pl_y;
          if ((round_q % 8'd5) == 8'd0) begin
            state_d = PLACE_VEG;
          end else begin
            veg_x_d = PARK_XY;
            veg_y_d = PARK_XY;
            fifth_d = 1'b0;
            state_d = PLAY;
          end
        end
      end
      PLACE_VEG: begin
        pl_go        = 1'b1;
        pl_size      = VEG_SIZE;
        pl_avoid2_en = 1'b1;
        if (pl_done) begin
          veg_x_d = pl_x;
          veg_y_d = pl_y;
          fifth_d = 1'b1;
          state_d = PLAY;
        end
      end
      OVER:    state_d = OVER;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      new_round_q <= 1'b0;
      veg_cons_q  <= 1'b0;
      win_q       <= 1'b0;
      fifth_q     <= 1'b0;
      snack_x_q   <= MAX_X >> 1;
      snack_y_q   <= MAX_Y >> 1;
      veg_x_q     <= PARK_XY;
      veg_y_q     <= PARK_XY;
      round_q     <= 8'd0;
      time_q      <= ROUND_SECS;
      tick_q      <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= start;
      new_round_q <= new_round;
      veg_cons_q  <= vegetable_consumed;
      win_q       <= win_d;
      fifth_q     <= fifth_d;
      snack_x_q   <= snack_x_d;
      snack_y_q   <= snack_y_d;
      veg_x_q     <= veg_x_d;
      veg_y_q     <= veg_y_d;
      round_q     <= round_d;
      time_q      <= time_d;
      tick_q      <= tick_d;
    end
  end

  assign game_state     = (state_q == PLAY);
  assign game_over      = (state_q == OVER);
  assign win            = win_q;
  assign is_fifth_round = fifth_q;
  assign snackX         = snack_x_q;
  assign snackY         = snack_y_q;
  assign vegetableX     = veg_x_q;
  assign vegetableY     = veg_y_q;
  assign round_num      = round_q;
  assign time_left      = time_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: timer vector table, randomized rounds against a
// placement model, and hand-written win / mid-placement reset sequences.
module tb_round_sequencer;
  import game_pkg::*;

  logic               clk = 1'b0;
  logic               rst, start, new_round, vegetable_consumed;
  logic [7:0]         score;
  logic signed [10:0] posX, posY, posX_end, posY_end;
  logic               game_state, game_over, win, is_fifth_round;
  logic [10:0]        snackX, snackY, vegetableX, vegetableY;
  logic [7:0]         round_num, time_left;
  state_t             dbg_state;

  int checks = 0;
  int failures = 0;
  logic [15:0] m_lfsr;
  logic [21:0] exp_q[$];
  int pig_x0, pig_y0, pig_x1, pig_y1;
  int exp_round, exp_vx, exp_vy, play_cnt;
  bit exp_fifth;

  typedef struct {
    int adv;
    int exp_time;
    int exp_gs;
    int exp_over;
  } timer_vec_t;
  timer_vec_t tvec[6];

  round_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .new_round(new_round),
    .vegetable_consumed(vegetable_consumed), .score(score),
    .posX(posX), .posY(posY), .posX_end(posX_end), .posY_end(posY_end),
    .game_state(game_state), .game_over(game_over), .win(win),
    .is_fifth_round(is_fifth_round), .snackX(snackX), .snackY(snackY),
    .vegetableX(vegetableX), .vegetableY(vegetableY),
    .round_num(round_num), .time_left(time_left), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Reference LFSR: seeded in reset, one step per clock otherwise.
  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= lfsr_step(m_lfsr);
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic bit disjoint(input int cx, input int cy, input int sz,
                                  input int x0, input int y0, input int x1, input int y1);
    return (cx + sz <= x0) || (cx >= x1) || (cy + sz <= y0) || (cy >= y1);
  endfunction

  // First legal candidate among up to 16 successive LFSR states, else fallback.
  task automatic model_place(input logic [15:0] l0, input bit use_snack, input int bx,
                             input int by, output int x, output int y, output int k);
    logic [15:0] l;
    int cx, cy;
    bit found;
    l = l0; found = 0; k = 16; x = 0; y = 0;
    for (int i = 0; i < 16 && !found; i++) begin
      cx = 8 + int'(l[9:0]);
      cy = 8 + int'(l[15:7]);
      if (cx + 16 <= 632 && cy + 16 <= 472 &&
          disjoint(cx, cy, 16, pig_x0, pig_y0, pig_x1, pig_y1) &&
          (!use_snack || disjoint(cx, cy, 16, bx, by, bx + 16, by + 16))) begin
        x = cx; y = cy; k = i; found = 1;
      end
      l = lfsr_step(l);
    end
    if (!found) begin
      if (disjoint(8, 8, 16, pig_x0, pig_y0, pig_x1, pig_y1) &&
          (!use_snack || disjoint(8, 8, 16, bx, by, bx + 16, by + 16))) begin
        x = 8; y = 8;
      end else begin
        x = 616; y = 456;
      end
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_pig(input int x0, input int y0, input int x1, input int y1);
    pig_x0 = x0; pig_y0 = y0; pig_x1 = x1; pig_y1 = y1;
    posX = 11'(x0); posY = 11'(y0); posX_end = 11'(x1); posY_end = 11'(y1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"}, int'(dbg_state), int'(IDLE));
    check({tag, "_game_state"}, game_state, 0);
    check({tag, "_game_over"}, game_over, 0);
    check({tag, "_win"}, win, 0);
    check({tag, "_fifth"}, is_fifth_round, 0);
    check({tag, "_snackX"}, snackX, 316);
    check({tag, "_snackY"}, snackY, 236);
    check({tag, "_vegX"}, vegetableX, 2000);
    check({tag, "_vegY"}, vegetableY, 2000);
    check({tag, "_round"}, round_num, 0);
    check({tag, "_time"}, time_left, 30);
  endtask

  task automatic run_round(input bit hold, input int wait_cyc, output int lat);
    int sx, sy, k1, vx, vy, k2, exp_lat;
    logic [15:0] l;
    logic [21:0] e;
    bit veg;
    tick(wait_cyc);
    play_cnt += wait_cyc;
    check("time_pre", time_left, 30 - play_cnt / 25);
    new_round = 1'b1;
    tick(1);
    if (exp_round < 255) exp_round++;
    check("round_num", round_num, exp_round);
    check("freeze_gs", game_state, 0);
    check("time_reload", time_left, 30);
    model_place(m_lfsr, 1'b0, 0, 0, sx, sy, k1);
    exp_q.push_back({sx[10:0], sy[10:0]});
    exp_lat = k1 + 1;
    veg = (exp_round % 5) == 0;
    if (veg) begin
      l = m_lfsr;
      repeat (k1 + 1) l = lfsr_step(l);
      model_place(l, 1'b1, sx, sy, vx, vy, k2);
      exp_lat += k2 + 1;
      exp_vx = vx; exp_vy = vy;
    end else begin
      exp_vx = 2000; exp_vy = 2000;
    end
    exp_fifth = veg;
    if (!hold) new_round = 1'b0;
    lat = 0;
    while (game_state !== 1'b1 && lat < 40) begin
      tick(1);
      lat++;
    end
    check("freeze_cycles", lat, exp_lat);
    e = exp_q.pop_front();
    check("snackX", snackX, int'(e[21:11]));
    check("snackY", snackY, int'(e[10:0]));
    check("vegX", vegetableX, exp_vx);
    check("vegY", vegetableY, exp_vy);
    check("fifth", is_fifth_round, exp_fifth);
    check("time_after", time_left, 30);
    play_cnt = 0;
    if (hold) begin
      tick(3);
      play_cnt = 3;
      new_round = 1'b0;
      check("hold_no_retrig", round_num, exp_round);
    end
  endtask

  task automatic consume();
    vegetable_consumed = 1'b1;
    tick(1);
    check("consumed_vegX", vegetableX, 2000);
    check("consumed_vegY", vegetableY, 2000);
    check("consumed_fifth", is_fifth_round, 1);
    vegetable_consumed = 1'b0;
    tick(1);
    play_cnt += 2;
    exp_vx = 2000; exp_vy = 2000;
  endtask

  initial begin
    int lat, x0, y0;
    tvec[0] = '{24, 30, 1, 0};
    tvec[1] = '{1, 29, 1, 0};
    tvec[2] = '{50, 27, 1, 0};
    tvec[3] = '{25, 26, 1, 0};
    tvec[4] = '{649, 1, 1, 0};
    tvec[5] = '{1, 0, 0, 1};

    rst = 1'b1; start = 1'b0; new_round = 1'b0; vegetable_consumed = 1'b0; score = 8'd0;
    set_pig(300, 220, 340, 260);
    tick(3);
    check_reset("reset");
    rst = 1'b0;
    tick(1);

    // start, countdown and expiry
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("start_gs", game_state, 1);
    check("start_time", time_left, 30);
    for (int i = 0; i < 6; i++) begin
      tick(tvec[i].adv);
      check($sformatf("timer%0d_time", i), time_left, tvec[i].exp_time);
      check($sformatf("timer%0d_gs", i), game_state, tvec[i].exp_gs);
      check($sformatf("timer%0d_over", i), game_over, tvec[i].exp_over);
    end
    check("expiry_win", win, 0);
    start = 1'b1; tick(2); start = 1'b0; tick(2);
    check("over_sticky", game_over, 1);
    check("over_gs", game_state, 0);

    // randomized rounds against the placement model
    rst = 1'b1; tick(2);
    check_reset("rerst");
    rst = 1'b0;
    start = 1'b1; tick(1); start = 1'b0;
    play_cnt = 0; exp_round = 0; exp_fifth = 0; exp_vx = 2000; exp_vy = 2000;
    for (int r = 1; r <= 20; r++) begin
      if (r == 1) set_pig(300, 220, 340, 260);
      else if (r == 6 || $urandom_range(0, 5) == 0) set_pig(0, 0, 640, 480);
      else begin
        x0 = $urandom_range(0, 600);
        y0 = $urandom_range(0, 440);
        set_pig(x0, y0, x0 + $urandom_range(8, 200), y0 + $urandom_range(8, 200));
      end
      run_round(r == 1, $urandom_range(1, 200), lat);
      if (r == 6) begin
        check("fallback_lat", lat, 17);
        check("fallback_x", snackX, 616);
        check("fallback_y", snackY, 456);
      end
      if (exp_fifth && (r == 5 || $urandom_range(0, 1) == 1)) consume();
    end

    // win has priority over a same-cycle new_round
    tick(1);
    score = 8'd99;
    new_round = 1'b1;
    tick(1);
    check("win", win, 1);
    check("win_over", game_over, 1);
    check("win_gs", game_state, 0);
    check("win_round", round_num, exp_round);
    check("win_no_place", int'(dbg_state), int'(OVER));
    new_round = 1'b0;
    tick(3);
    check("win_absorb", int'(dbg_state), int'(OVER));

    // reset while a placement is in progress
    rst = 1'b1; tick(2); rst = 1'b0; score = 8'd0;
    start = 1'b1; tick(1); start = 1'b0;
    set_pig(0, 0, 640, 480);
    new_round = 1'b1; tick(1); new_round = 1'b0;
    tick(3);
    check("mid_place", int'(dbg_state), int'(PLACE));
    rst = 1'b1;
    tick(1);
    check_reset("midrst");
    rst = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
